// File: rtl/sipo_frame.sv
// Framed serial-to-parallel deserializer: assembles WORDS words of WIDTH bits into a
// one-entry valid/ready output register. Also reports the word index, frame done and overrun.
module sipo_frame #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned WORDS      = 9,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          AUTO_REARM = 1'b0,
  parameter int unsigned IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in,
  input  logic             i_in_valid,
  input  logic             i_start,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out,
  output logic             o_out_valid,
  output logic [IDX_W-1:0] o_word_idx,
  output logic             o_frame_done,
  output logic             o_overrun,
  output logic             o_busy
);

  localparam int unsigned      CNT_W     = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORDS - 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_d;
  logic [IDX_W-1:0]   r_wcnt, w_wcnt_d;
  logic [WIDTH-1:0]   r_sr, w_sr_d;
  logic [WIDTH-1:0]   r_out, w_out_d;
  logic               r_out_valid, w_out_valid_d;
  logic [IDX_W-1:0]   r_word_idx, w_word_idx_d;
  logic               r_frame_done, w_frame_done_d;
  logic               r_overrun, w_overrun_d;
  logic [WIDTH-1:0]   w_sr_shifted;

  // The shifted value already contains the current bit, so a completing word loads from it.
  assign w_sr_shifted = MSB_FIRST ? {r_sr[WIDTH-2:0], i_in} : {i_in, r_sr[WIDTH-1:1]};

  always_comb begin
    w_state_d      = r_state;
    w_bit_cnt_d    = r_bit_cnt;
    w_wcnt_d       = r_wcnt;
    w_sr_d         = r_sr;
    w_out_d        = r_out;
    w_out_valid_d  = r_out_valid;
    w_word_idx_d   = r_word_idx;
    w_frame_done_d = 1'b0;
    w_overrun_d    = r_overrun;

    if (r_out_valid && i_out_ready) begin
      w_out_valid_d = 1'b0;
    end

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_d   = StShift;
          w_bit_cnt_d = '0;
          w_wcnt_d    = '0;
          w_overrun_d = 1'b0;
        end
      end
      StShift: begin
        if (i_in_valid) begin
          w_sr_d = w_sr_shifted;
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_cnt_d = '0;
            if (!r_out_valid || i_out_ready) begin
              w_out_d       = w_sr_shifted;
              w_word_idx_d  = r_wcnt;
              w_out_valid_d = 1'b1;
            end else begin
              w_overrun_d = 1'b1;
            end
            if (r_wcnt == WORD_LAST) begin
              w_wcnt_d       = '0;
              w_frame_done_d = 1'b1;
              if (!AUTO_REARM) begin
                w_state_d = StIdle;
              end
            end else begin
              w_wcnt_d = r_wcnt + IDX_W'(1);
            end
          end else begin
            w_bit_cnt_d = r_bit_cnt + CNT_W'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= StIdle;
      r_bit_cnt    <= '0;
      r_wcnt       <= '0;
      r_sr         <= '0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_word_idx   <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_bit_cnt    <= w_bit_cnt_d;
      r_wcnt       <= w_wcnt_d;
      r_sr         <= w_sr_d;
      r_out        <= w_out_d;
      r_out_valid  <= w_out_valid_d;
      r_word_idx   <= w_word_idx_d;
      r_frame_done <= w_frame_done_d;
      r_overrun    <= w_overrun_d;
    end
  end

  assign o_out        = r_out;
  assign o_out_valid  = r_out_valid;
  assign o_word_idx   = r_word_idx;
  assign o_frame_done = r_frame_done;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state == StShift);

endmodule

// File: doc/sipo_frame.md
# sipo_frame

Parametrised serial-to-parallel deserializer for framed serial data. It collects WORDS words of WIDTH bits each from a bit-qualified serial input and presents each word on a one-entry output register with a valid/ready handshake. It also reports the frame index, a frame-done pulse and a sticky overrun flag. It sits between the serial front end and the word-level consumer, such as the triangle/vertex loader, and replaces the fixed 16-bit single-word deserializer.

## Interface
- WIDTH, 16, bits per word (≥2)
- WORDS, 9, words per frame (≥1)
- MSB_FIRST, 1, 1: first received bit lands in out[WIDTH-1]; 0: first bit lands in out[0]
- AUTO_REARM, 0, 1: start the next frame immediately after frame completion; 0: wait for start
- IDX_W, $clog2(WORDS) (min 1), width of word_idx

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset (rst==0 at a clk edge resets)
- in  in  1  serial data bit
- in_valid  in  1  qualifies in; one bit is consumed per cycle with in_valid=1 in SHIFT
- start  in  1  arms a new frame
- out  out  WIDTH  assembled word (output register)
- out_valid  out  1  out holds an unconsumed word
- out_ready  in  1  consumer accepts out when out_valid=1
- word_idx  out  IDX_W  index (0..WORDS-1) of the word currently in out
- frame_done  out  1  one-cycle pulse: last word of frame completed
- overrun  out  1  sticky: a completed word was dropped because out was still full
- busy  out  1  1 while in SHIFT

## Operation
- States:
  - IDLE (reset state): serial input ignored.
  - SHIFT: bits accepted.
- IDLE→SHIFT: on start=1. Clears bit_cnt, wcnt and overrun. out, out_valid and word_idx are untouched.
- SHIFT:
  - Each cycle with in_valid=1 shifts `in` into the shift register. MSB_FIRST=1: sr←{sr[WIDTH-2:0],in}. MSB_FIRST=0: sr←{in,sr[WIDTH-1:1]}.
  - bit_cnt counts 0..WIDTH-1.
- Word completion: in_valid=1 with bit_cnt==WIDTH-1.
  - bit_cnt←0.
  - If out is free (out_valid=0, or out_ready=1 this cycle), then out←completed word (including the current bit), word_idx←wcnt, out_valid←1.
  - Otherwise the word is discarded and overrun←1. out, out_valid and word_idx are unchanged.
  - wcnt advances in both cases.
- Frame completion: word completion with wcnt==WORDS-1.
  - frame_done←1 for exactly one cycle and wcnt←0.
  - AUTO_REARM=0: next state is IDLE.
  - AUTO_REARM=1: stay in SHIFT. overrun is not cleared.
- start in SHIFT is ignored. start in the same cycle as frame completion is ignored when AUTO_REARM=0; start must be reasserted once in IDLE.
- Handshake: a transfer occurs when out_valid&&out_ready. On transfer without a simultaneous load, out_valid←0 and out holds its last value. Transfer and load in the same cycle leaves out_valid=1 with the new word.
- overrun clears only on reset or on IDLE→SHIFT.
- Counters never wrap past their limits; wcnt is bounded by WORDS-1.

## Timing
- Reset values (rst=0 at edge): out=0, out_valid=0, word_idx=0, frame_done=0, overrun=0, busy=0, state IDLE, bit_cnt=0, wcnt=0, sr=0. Reset overrides all other inputs, including mid-frame; the partial word is lost.
- A start sampled at edge N gives busy=1 after N. The first bit can be accepted at edge N+1.
- Latency: the last bit of a word sampled at edge K gives out/out_valid/word_idx updated after K. frame_done is high in cycle K→K+1 only.
- With in_valid held high, words complete every WIDTH cycles and a frame takes WIDTH*WORDS cycles after arming.
- out_valid deasserts the cycle after the accepting edge. out_ready has no combinational path to any output.

## Test plan
- Basic MSB-first: WIDTH=16, WORDS=2. start, then stream 0xA5C3 and 0x1234 MSB first with in_valid=1 and out_ready=1 → out=0xA5C3 with word_idx=0 after bit 16, then out=0x1234 with word_idx=1 and frame_done pulse after bit 32. busy=0 afterward; further bits are ignored until start.
- LSB-first and gaps: MSB_FIRST=0, send 0x00F1 LSB first with random in_valid gaps → out=0x00F1. Bits with in_valid=0 are not consumed.
- Backpressure/overrun: out_ready=0 for the whole frame, WORDS=3 → word0 is held, words 1 and 2 are dropped, overrun=1, and frame_done still pulses. A later start clears overrun.
- Simultaneous accept and load: out_ready=1 exactly on the edge the next word completes → out_valid stays 1, new word present, overrun=0.
- AUTO_REARM=1: two back-to-back frames with no start between them → word_idx sequence 0..WORDS-1, 0..WORDS-1, two frame_done pulses, busy stays 1.
- Reset mid-word: rst=0 after 7 bits → all outputs at their reset values. After start, a full 16-bit word assembles correctly with no residue from the partial word.
